// File: rtl/layer_conf_pkg.sv
// Shared register map, default timings and payload types for the layer configuration bank.
package layer_conf_pkg;

    localparam logic [2:0] REG_T0H    = 3'd0;
    localparam logic [2:0] REG_T0L    = 3'd1;
    localparam logic [2:0] REG_T1H    = 3'd2;
    localparam logic [2:0] REG_T1L    = 3'd3;
    localparam logic [2:0] REG_RST_HI = 3'd4;
    localparam logic [2:0] REG_RST_LO = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_INFO   = 3'd7;

    localparam int unsigned CTRL_COMMIT_BIT = 0;

    localparam logic [7:0]  T0H_DEF_C = 8'd16;
    localparam logic [7:0]  T0L_DEF_C = 8'd34;
    localparam logic [7:0]  T1H_DEF_C = 8'd32;
    localparam logic [7:0]  T1L_DEF_C = 8'd18;
    localparam logic [15:0] RST_DEF_C = 16'd2500;

    // One channel's full timing set; count fields hold at most 8 significant bits.
    typedef struct packed {
        logic [7:0]  t0h;
        logic [7:0]  t0l;
        logic [7:0]  t1h;
        logic [7:0]  t1l;
        logic [15:0] rst;
    } timing_t;

    // Mask keeping the low w bits of a byte-wide count.
    function automatic logic [7:0] cnt_mask(input int unsigned w);
        return 8'((16'd1 << w) - 16'd1);
    endfunction

endpackage

// File: rtl/layer_conf_ch.sv
// One channel: host-written shadow set, idle-gated transfer into the active set.
module layer_conf_ch
    import layer_conf_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter logic [7:0]  T0H_DEF = T0H_DEF_C,
    parameter logic [7:0]  T0L_DEF = T0L_DEF_C,
    parameter logic [7:0]  T1H_DEF = T1H_DEF_C,
    parameter logic [7:0]  T1L_DEF = T1L_DEF_C,
    parameter logic [15:0] RST_DEF = RST_DEF_C
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       wr_en_in,
    input  logic [2:0] wr_idx_in,
    input  logic [7:0] wr_data_in,
    input  logic       commit_in,
    input  logic       idle_in,
    output timing_t    shadow_out,
    output timing_t    active_out,
    output logic       pending_out
);

    localparam logic [7:0] CNT_MASK = cnt_mask(CNT_W);
    localparam timing_t    DEF_SET  = '{
        t0h: T0H_DEF & CNT_MASK,
        t0l: T0L_DEF & CNT_MASK,
        t1h: T1H_DEF & CNT_MASK,
        t1l: T1L_DEF & CNT_MASK,
        rst: RST_DEF
    };

    timing_t r_shadow;
    timing_t r_active;
    logic    r_pending;
    logic    w_xfer;

    assign w_xfer = r_pending & idle_in;

    // Shadow bytes take host writes; count bytes keep only CNT_W bits.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_shadow <= DEF_SET;
        end else if (wr_en_in) begin
            case (wr_idx_in)
                REG_T0H:    r_shadow.t0h       <= wr_data_in & CNT_MASK;
                REG_T0L:    r_shadow.t0l       <= wr_data_in & CNT_MASK;
                REG_T1H:    r_shadow.t1h       <= wr_data_in & CNT_MASK;
                REG_T1L:    r_shadow.t1l       <= wr_data_in & CNT_MASK;
                REG_RST_HI: r_shadow.rst[15:8] <= wr_data_in;
                REG_RST_LO: r_shadow.rst[7:0]  <= wr_data_in;
                default:    ;
            endcase
        end
    end

    // Active set copies the pre-write shadow when a pending commit meets an idle channel.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_active <= DEF_SET;
        end else if (w_xfer) begin
            r_active <= r_shadow;
        end
    end

    // Pending: a new commit wins over the clear caused by a same-edge transfer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pending <= 1'b0;
        end else if (commit_in) begin
            r_pending <= 1'b1;
        end else if (w_xfer) begin
            r_pending <= 1'b0;
        end
    end

    assign shadow_out  = r_shadow;
    assign active_out  = r_active;
    assign pending_out = r_pending;

endmodule

// File: rtl/layer_conf_bank.sv
// Multi-channel LED timing bank: address decode, per-channel instances, read-back and output packing.
module layer_conf_bank
    import layer_conf_pkg::*;
#(
    parameter int unsigned  NUM_CH  = 4,
    parameter int unsigned  CNT_W   = 8,
    parameter logic [7:0]   T0H_DEF = T0H_DEF_C,
    parameter logic [7:0]   T0L_DEF = T0L_DEF_C,
    parameter logic [7:0]   T1H_DEF = T1H_DEF_C,
    parameter logic [7:0]   T1L_DEF = T1L_DEF_C,
    parameter logic [15:0]  RST_DEF = RST_DEF_C,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned ADDR_W  = CH_W + 3
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    wr_en_in,
    input  logic [ADDR_W-1:0]       wr_addr_in,
    input  logic [7:0]              wr_data_in,
    input  logic [ADDR_W-1:0]       rd_addr_in,
    output logic [7:0]              rd_data_out,
    input  logic [NUM_CH-1:0]       ch_idle_in,
    output logic [NUM_CH-1:0]       pending_out,
    output logic [NUM_CH*CNT_W-1:0] t0h_cnt_out,
    output logic [NUM_CH*CNT_W-1:0] t0l_cnt_out,
    output logic [NUM_CH*CNT_W-1:0] t1h_cnt_out,
    output logic [NUM_CH*CNT_W-1:0] t1l_cnt_out,
    output logic [NUM_CH*16-1:0]    rst_cnt_out
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [CH_W-1:0]   w_wr_ch;
    logic [2:0]        w_wr_idx;
    logic              w_wr_ok;
    logic [CH_W-1:0]   w_rd_ch;
    logic [2:0]        w_rd_idx;
    logic              w_rd_ok;
    logic [7:0]        w_rd_data;
    logic [7:0]        r_rd_data;
    logic [NUM_CH-1:0] w_pending;
    timing_t           w_shadow [NUM_CH];
    timing_t           w_active [NUM_CH];

    assign w_wr_ch  = wr_addr_in[ADDR_W-1:3];
    assign w_wr_idx = wr_addr_in[2:0];
    assign w_wr_ok  = ({1'b0, w_wr_ch} < NUM_CH_L);
    assign w_rd_ch  = rd_addr_in[ADDR_W-1:3];
    assign w_rd_idx = rd_addr_in[2:0];
    assign w_rd_ok  = ({1'b0, w_rd_ch} < NUM_CH_L);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_sel;
        logic w_shadow_wr;
        logic w_commit;

        assign w_sel       = wr_en_in && w_wr_ok && (w_wr_ch == CH_W'(c));
        assign w_shadow_wr = w_sel && (w_wr_idx <= REG_RST_LO);
        assign w_commit    = w_sel && (w_wr_idx == REG_CTRL) && wr_data_in[CTRL_COMMIT_BIT];

        layer_conf_ch #(
            .CNT_W   (CNT_W),
            .T0H_DEF (T0H_DEF),
            .T0L_DEF (T0L_DEF),
            .T1H_DEF (T1H_DEF),
            .T1L_DEF (T1L_DEF),
            .RST_DEF (RST_DEF)
        ) u_ch (
            .clk_in      (clk_in),
            .rst_n_in    (rst_n_in),
            .wr_en_in    (w_shadow_wr),
            .wr_idx_in   (w_wr_idx),
            .wr_data_in  (wr_data_in),
            .commit_in   (w_commit),
            .idle_in     (ch_idle_in[c]),
            .shadow_out  (w_shadow[c]),
            .active_out  (w_active[c]),
            .pending_out (w_pending[c])
        );

        assign t0h_cnt_out[c*CNT_W +: CNT_W] = w_active[c].t0h[CNT_W-1:0];
        assign t0l_cnt_out[c*CNT_W +: CNT_W] = w_active[c].t0l[CNT_W-1:0];
        assign t1h_cnt_out[c*CNT_W +: CNT_W] = w_active[c].t1h[CNT_W-1:0];
        assign t1l_cnt_out[c*CNT_W +: CNT_W] = w_active[c].t1l[CNT_W-1:0];
        assign rst_cnt_out[c*16 +: 16]       = w_active[c].rst;
    end

    // Read-back mux: shadow bytes, pending status, channel count; unmapped channels read zero.
    always_comb begin
        w_rd_data = 8'h00;
        if (w_rd_ok) begin
            case (w_rd_idx)
                REG_T0H:    w_rd_data = w_shadow[w_rd_ch].t0h;
                REG_T0L:    w_rd_data = w_shadow[w_rd_ch].t0l;
                REG_T1H:    w_rd_data = w_shadow[w_rd_ch].t1h;
                REG_T1L:    w_rd_data = w_shadow[w_rd_ch].t1l;
                REG_RST_HI: w_rd_data = w_shadow[w_rd_ch].rst[15:8];
                REG_RST_LO: w_rd_data = w_shadow[w_rd_ch].rst[7:0];
                REG_CTRL:   w_rd_data = {7'b0, w_pending[w_rd_ch]};
                default:    w_rd_data = 8'(NUM_CH);
            endcase
        end
    end

    // Read data registered for a fixed one-cycle latency.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= w_rd_data;
        end
    end

    assign rd_data_out = r_rd_data;
    assign pending_out = w_pending;

endmodule

// File: tb/tb_layer_conf_bank.sv
// Bench for layer_conf_bank: directed scenarios plus randomized traffic against an array-based model.
`timescale 1ns/1ps
module tb_layer_conf_bank;

    localparam int NCH = 4;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [3:0]  idle;
    logic [3:0]  pending;
    logic [31:0] t0h, t0l, t1h, t1l;
    logic [63:0] rcnt;

    // Three-channel instance: exposes channel codes that map to no channel.
    logic        wr_en3;
    logic [4:0]  wr_addr3;
    logic [7:0]  wr_data3;
    logic [4:0]  rd_addr3;
    logic [7:0]  rd_data3;
    logic [2:0]  idle3;
    logic [2:0]  pending3;
    logic [23:0] t0h3, t0l3, t1h3, t1l3;
    logic [47:0] rcnt3;

    int n_tests;
    int n_fail;

    // Model state: field 0..3 = T0H,T0L,T1H,T1L, field 4 = 16-bit reset gap.
    int m_sh  [NCH][5];
    int m_act [NCH][5];
    bit m_pend[NCH];
    int m_rd;

    layer_conf_bank u_dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .wr_en_in    (wr_en),
        .wr_addr_in  (wr_addr),
        .wr_data_in  (wr_data),
        .rd_addr_in  (rd_addr),
        .rd_data_out (rd_data),
        .ch_idle_in  (idle),
        .pending_out (pending),
        .t0h_cnt_out (t0h),
        .t0l_cnt_out (t0l),
        .t1h_cnt_out (t1h),
        .t1l_cnt_out (t1l),
        .rst_cnt_out (rcnt)
    );

    layer_conf_bank #(.NUM_CH(3)) u_dut3 (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .wr_en_in    (wr_en3),
        .wr_addr_in  (wr_addr3),
        .wr_data_in  (wr_data3),
        .rd_addr_in  (rd_addr3),
        .rd_data_out (rd_data3),
        .ch_idle_in  (idle3),
        .pending_out (pending3),
        .t0h_cnt_out (t0h3),
        .t0l_cnt_out (t0l3),
        .t1h_cnt_out (t1h3),
        .t1l_cnt_out (t1l3),
        .rst_cnt_out (rcnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sh[c]  = '{16, 34, 32, 18, 2500};
            m_act[c] = '{16, 34, 32, 18, 2500};
            m_pend[c] = 1'b0;
        end
        m_rd = 0;
    endfunction

    // One clock edge of the register bank, applied from the behavioural rules.
    function automatic void model_step();
        int rc, ri, wc, wi;
        bit xfer [NCH];
        bit setp [NCH];
        rc = int'(rd_addr) / 8;
        ri = int'(rd_addr) % 8;
        if (rc >= NCH)   m_rd = 0;
        else if (ri < 4) m_rd = m_sh[rc][ri];
        else if (ri == 4) m_rd = m_sh[rc][4] / 256;
        else if (ri == 5) m_rd = m_sh[rc][4] % 256;
        else if (ri == 6) m_rd = int'(m_pend[rc]);
        else              m_rd = NCH;
        for (int c = 0; c < NCH; c++) begin
            xfer[c] = m_pend[c] && idle[c];
            setp[c] = 1'b0;
            if (xfer[c]) m_act[c] = m_sh[c];
        end
        wc = int'(wr_addr) / 8;
        wi = int'(wr_addr) % 8;
        if (wr_en && wc < NCH) begin
            if (wi < 4)       m_sh[wc][wi] = int'(wr_data);
            else if (wi == 4) m_sh[wc][4] = int'(wr_data) * 256 + m_sh[wc][4] % 256;
            else if (wi == 5) m_sh[wc][4] = (m_sh[wc][4] / 256) * 256 + int'(wr_data);
            else if (wi == 6 && wr_data[0]) setp[wc] = 1'b1;
        end
        for (int c = 0; c < NCH; c++) begin
            if (setp[c])      m_pend[c] = 1'b1;
            else if (xfer[c]) m_pend[c] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] exp_cnt(input int f);
        logic [31:0] v;
        for (int c = 0; c < NCH; c++) v[c*8 +: 8] = 8'(m_act[c][f]);
        return v;
    endfunction

    function automatic logic [63:0] exp_rst();
        logic [63:0] v;
        for (int c = 0; c < NCH; c++) v[c*16 +: 16] = 16'(m_act[c][4]);
        return v;
    endfunction

    function automatic logic [3:0] exp_pend();
        logic [3:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_pend[c];
        return v;
    endfunction

    // Advance one clock edge; returns 1 ns after the edge with inputs still applied.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic wr(input int ch, input int idx, input int d);
        wr_en   = 1'b1;
        wr_addr = 5'(ch * 8 + idx);
        wr_data = 8'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        model_reset();
        n_tests++; if (t0h !== 32'h10101010) begin n_fail++; $display("FAIL reset_t0h got %h exp %h", t0h, 32'h10101010); end
        n_tests++; if (t0l !== 32'h22222222) begin n_fail++; $display("FAIL reset_t0l got %h exp %h", t0l, 32'h22222222); end
        n_tests++; if ({t1h, t1l} !== 64'h20202020_12121212) begin n_fail++; $display("FAIL reset_t1 got %h exp %h", {t1h, t1l}, 64'h20202020_12121212); end
        n_tests++; if (rcnt !== 64'h09C409C409C409C4) begin n_fail++; $display("FAIL reset_rst got %h exp %h", rcnt, 64'h09C409C409C409C4); end
        n_tests++; if (pending !== 4'h0 || rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_pend_rd got %h/%h exp 0/00", pending, rd_data); end
        rst_n   = 1'b1;
        rd_addr = 5'd1;
        tick();
        n_tests++; if (rd_data !== 8'd34) begin n_fail++; $display("FAIL reset_read_t0l got %0d exp 34", rd_data); end
    endtask

    task automatic test_commit();
        idle = 4'hF;
        wr(2, 0, 8'h0A);
        n_tests++; if (t0h !== 32'h10101010) begin n_fail++; $display("FAIL commit_no_early got %h exp %h", t0h, 32'h10101010); end
        rd_addr = 5'(2 * 8 + 0);
        tick();
        n_tests++; if (rd_data !== 8'h0A) begin n_fail++; $display("FAIL commit_shadow_read got %h exp 0a", rd_data); end
        wr(2, 6, 8'hFE);
        n_tests++; if (pending !== 4'h0) begin n_fail++; $display("FAIL commit_bit0_clear got %b exp 0000", pending); end
        wr(2, 6, 8'h01);
        n_tests++; if (pending !== 4'b0100 || t0h !== 32'h10101010) begin n_fail++; $display("FAIL commit_pending got %b/%h exp 0100/10101010", pending, t0h); end
        tick();
        n_tests++; if (pending !== 4'h0 || t0h !== 32'h100A1010) begin n_fail++; $display("FAIL commit_applied got %b/%h exp 0000/100a1010", pending, t0h); end
    endtask

    task automatic test_hold();
        idle = 4'b1101;
        wr(1, 4, 8'h12);
        wr(1, 5, 8'h34);
        wr(1, 6, 8'h01);
        rd_addr = 5'(1 * 8 + 6);
        repeat (20) tick();
        n_tests++; if (rcnt[31:16] !== 16'd2500) begin n_fail++; $display("FAIL hold_active got %h exp 09c4", rcnt[31:16]); end
        n_tests++; if (rd_data !== 8'h01 || pending !== 4'b0010) begin n_fail++; $display("FAIL hold_status got %h/%b exp 01/0010", rd_data, pending); end
        idle = 4'hF;
        tick();
        n_tests++; if (rcnt[31:16] !== 16'h1234 || pending !== 4'h0) begin n_fail++; $display("FAIL hold_release got %h/%b exp 1234/0000", rcnt[31:16], pending); end
        n_tests++; if (rcnt !== 64'h09C409C4_123409C4) begin n_fail++; $display("FAIL hold_others got %h exp %h", rcnt, 64'h09C409C4_123409C4); end
    endtask

    task automatic test_same_cycle();
        idle = 4'hF;
        wr(0, 2, 5);
        idle = 4'b1110;
        wr(0, 6, 1);
        wr_en = 1'b1; wr_addr = 5'(0 * 8 + 2); wr_data = 8'd9; idle = 4'hF;
        tick();
        wr_en = 1'b0;
        n_tests++; if (t1h[7:0] !== 8'd5 || pending[0] !== 1'b0) begin n_fail++; $display("FAIL same_wr_xfer got %0d/%b exp 5/0", t1h[7:0], pending[0]); end
        rd_addr = 5'(0 * 8 + 2);
        tick();
        n_tests++; if (rd_data !== 8'd9 || t1h[7:0] !== 8'd5) begin n_fail++; $display("FAIL same_shadow_keep got %0d/%0d exp 9/5", rd_data, t1h[7:0]); end
        idle = 4'b1110;
        wr_en = 1'b1; wr_addr = 5'(0 * 8 + 6); wr_data = 8'h01;
        tick();
        idle = 4'hF;
        tick();
        n_tests++; if (pending[0] !== 1'b1 || t1h[7:0] !== 8'd9) begin n_fail++; $display("FAIL same_commit_xfer got %b/%0d exp 1/9", pending[0], t1h[7:0]); end
        idle = 4'b1110;
        wr_addr = 5'(0 * 8 + 2); wr_data = 8'd7;
        tick();
        wr_en = 1'b0;
        n_tests++; if (pending[0] !== 1'b1 || t1h[7:0] !== 8'd9) begin n_fail++; $display("FAIL same_hold got %b/%0d exp 1/9", pending[0], t1h[7:0]); end
        idle = 4'hF;
        tick();
        n_tests++; if (pending[0] !== 1'b0 || t1h[7:0] !== 8'd7) begin n_fail++; $display("FAIL same_second_xfer got %b/%0d exp 0/7", pending[0], t1h[7:0]); end
    endtask

    task automatic test_out_of_range();
        idle3  = 3'b111;
        wr_en3 = 1'b1; wr_addr3 = 5'(3 * 8 + 0); wr_data3 = 8'hFF;
        tick();
        wr_addr3 = 5'(3 * 8 + 6); wr_data3 = 8'h01;
        tick();
        wr_en3 = 1'b0;
        tick();
        n_tests++; if (t0h3 !== 24'h101010 || pending3 !== 3'b000) begin n_fail++; $display("FAIL oor_no_effect got %h/%b exp 101010/000", t0h3, pending3); end
        n_tests++; if (rcnt3 !== 48'h09C409C409C4) begin n_fail++; $display("FAIL oor_rst got %h exp 09c409c409c4", rcnt3); end
        rd_addr3 = 5'(3 * 8 + 0);
        tick();
        n_tests++; if (rd_data3 !== 8'h00) begin n_fail++; $display("FAIL oor_read got %h exp 00", rd_data3); end
        rd_addr3 = 5'(3 * 8 + 7);
        tick();
        n_tests++; if (rd_data3 !== 8'h00) begin n_fail++; $display("FAIL oor_read_info got %h exp 00", rd_data3); end
        rd_addr3 = 5'(0 * 8 + 7);
        tick();
        n_tests++; if (rd_data3 !== 8'd3) begin n_fail++; $display("FAIL info3 got %0d exp 3", rd_data3); end
        rd_addr3 = 5'(0 * 8 + 0);
        tick();
        n_tests++; if (rd_data3 !== 8'd16) begin n_fail++; $display("FAIL oor_no_alias got %0d exp 16", rd_data3); end
        rd_addr = 5'(0 * 8 + 7);
        tick();
        n_tests++; if (rd_data !== 8'd4) begin n_fail++; $display("FAIL info4 got %0d exp 4", rd_data); end
    endtask

    task automatic test_random();
        logic [203:0] got;
        logic [203:0] exp;
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom);
            wr_data = 8'($urandom);
            rd_addr = 5'($urandom);
            idle    = 4'($urandom);
            tick();
            got = {t0h, t0l, t1h, t1l, rcnt, pending, rd_data};
            exp = {exp_cnt(0), exp_cnt(1), exp_cnt(2), exp_cnt(3), exp_rst(), exp_pend(), 8'(m_rd)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand_cycle_%0d got %h exp %h", i, got, exp);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_async_reset();
        idle = 4'b0111;
        wr(3, 0, 8'h55);
        wr(3, 6, 8'h01);
        n_tests++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL areset_setup got %b exp 1", pending[3]); end
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++; if (t0h !== 32'h10101010 || pending !== 4'h0) begin n_fail++; $display("FAIL areset_immediate got %h/%b exp 10101010/0000", t0h, pending); end
        n_tests++; if (rcnt !== 64'h09C409C409C409C4 || rd_data !== 8'h00) begin n_fail++; $display("FAIL areset_rst_rd got %h/%h exp 09c409c409c409c4/00", rcnt, rd_data); end
        #2;
        rst_n = 1'b1;
        idle  = 4'hF;
        repeat (3) tick();
        n_tests++; if (t0h[31:24] !== 8'd16 || pending !== 4'h0) begin n_fail++; $display("FAIL areset_no_xfer got %0d/%b exp 16/0000", t0h[31:24], pending); end
        rd_addr = 5'(3 * 8 + 0);
        tick();
        n_tests++; if (rd_data !== 8'd16) begin n_fail++; $display("FAIL areset_shadow got %0d exp 16", rd_data); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        idle     = '0;
        wr_en3   = 1'b0;
        wr_addr3 = '0;
        wr_data3 = '0;
        rd_addr3 = '0;
        idle3    = '0;
        model_reset();
        test_reset();
        test_commit();
        test_hold();
        test_same_cycle();
        test_out_of_range();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_conf_bank.md
Name: layer_conf_bank

Overview:
- Parametrised successor to the single-channel LED timing register block.
- Holds NeoPixel bit-timing and reset-gap counts for NUM_CH output channels, each with a shadow register set (host-written) and an active set (driving the waveform generators).
- Shadow-to-active transfer is requested per channel and executes only when that channel reports idle, so timing never changes mid-frame.
- Adds registered read-back of shadow values and status. Sits between the SPI/host register decoder and the per-channel waveform layers.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 8, width of T0H/T0L/T1H/T1L counts (1..8); write data above CNT_W bits discarded.
- T0H_DEF, 8'd16, reset value of every T0H count (shadow and active).
- T0L_DEF, 8'd34, reset value of T0L.
- T1H_DEF, 8'd32, reset value of T1H.
- T1L_DEF, 8'd18, reset value of T1L.
- RST_DEF, 16'd2500, reset value of 16-bit reset-gap count.
- Derived localparams: CH_W = max(1, clog2(NUM_CH)); ADDR_W = CH_W+3.

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, asynchronous active-low reset.
- wr_en_in, input, 1, write strobe, one write per high cycle.
- wr_addr_in, input, ADDR_W, [ADDR_W-1:3] channel, [2:0] register index.
- wr_data_in, input, 8, write data.
- rd_addr_in, input, ADDR_W, read address, same layout.
- rd_data_out, output, 8, registered read data.
- ch_idle_in, input, NUM_CH, per-channel "between frames" flag from waveform layer.
- pending_out, output, NUM_CH, commit requested, not yet applied.
- t0h_cnt_out, output, NUM_CH*CNT_W, active T0H, channel c at [c*CNT_W +: CNT_W]; same packing for t0l/t1h/t1l.
- t0l_cnt_out, output, NUM_CH*CNT_W, active T0L.
- t1h_cnt_out, output, NUM_CH*CNT_W, active T1H.
- t1l_cnt_out, output, NUM_CH*CNT_W, active T1L.
- rst_cnt_out, output, NUM_CH*16, active reset-gap count.

Behaviour:
- Register index map: 0 T0H, 1 T0L, 2 T1H, 3 T1L, 4 RST[15:8], 5 RST[7:0], 6 CTRL/STATUS, 7 INFO.
- Writes to 0..5 update the addressed channel's shadow on the clock edge. Active outputs are unaffected.
- Write to 6 with wr_data_in[0]=1 sets pending[ch]; bit0=0 is a no-op; bits 7:1 are ignored. Writes to 7 are ignored.
- Writes with channel field >= NUM_CH are ignored entirely.
- Transfer: at each edge where pending[c] & ch_idle_in[c], all five active values of c load from shadow and pending[c] clears.
  - Earliest transfer is the edge after the one that set pending (1-cycle minimum latency).
  - While ch_idle_in[c]=0, pending holds indefinitely.
- Same-cycle shadow write and transfer on a channel: active takes the pre-write shadow; the new byte stays in shadow only.
- Same-cycle commit write and transfer on a channel: pending remains 1 (set wins); a second transfer follows at the next idle edge.
- Re-commit while already pending: no change. Channels operate independently; several may transfer on the same edge.
- Read: rd_data_out is updated every cycle from rd_addr_in (1-cycle latency).
  - Index 0..5 return the shadow value, zero-extended above CNT_W.
  - Index 6 returns {7'b0, pending[ch]}.
  - Index 7 returns NUM_CH.
  - Channel field >= NUM_CH returns 8'h00.
- Reset (any time, including mid-pending): shadow and active = *_DEF truncated to CNT_W; pending_out = 0; rd_data_out = 8'h00. The transfer is abandoned.

Decomposition:
- Package layer_conf_pkg: register index constants (REG_T0H..REG_INFO), CTRL_COMMIT_BIT, default timing constants, and a struct typedef timing_t {t0h, t0l, t1h, t1l, rst}.
- One natural sub-module, layer_conf_ch: a single channel's shadow/active/pending logic, generate-instantiated NUM_CH times. The top holds address decode, idle fan-in, the read mux and output packing.

Test Plan:
- Reset with defaults -> all t0h slices = 16, rst slices = 2500, pending_out = 0, read ch0 idx1 gives 34 one cycle later.
- Write ch2 idx0 = 8'h0A with ch_idle_in = all 1, no commit -> t0h ch2 still 16. Read ch2 idx0 = 8'h0A. Commit ch2 -> pending[2] high for exactly 1 cycle, then t0h ch2 = 10, other channels unchanged.
- Write ch1 RST hi = 8'h12, lo = 8'h34, commit with ch_idle_in[1] = 0 for 20 cycles -> rst ch1 stays 2500, status read = 1. Raise idle -> rst ch1 = 16'h1234 next edge, pending clears.
- Same-cycle transfer and shadow write (ch0 T1H 5 pending, idle rises as T1H = 9 is written) -> active = 5, shadow read = 9. Same-cycle commit write and transfer -> pending stays 1, then active = 9.
- Write to channel NUM_CH (e.g. 4) idx0 = 8'hFF and commit -> no output or pending change. Read of it returns 8'h00. Idx7 read returns 4.
- Assert rst_n_in asynchronously while pending[3] = 1 with modified shadow -> outputs return to defaults immediately, pending clears, and nothing transfers after reset release.
